// File: rtl/game_sequencer_if.sv
// Event/status bundle between the game sequencer and its timer/play logic.
// The sequencer uses the slave view; the environment uses the master view.
interface game_sequencer_if;
  logic            start_key;
  logic            one_sec;
  logic            out_of_time;
  logic            player_hit;
  logic            level_done;
  logic            timer_load;
  logic [1:0][3:0] time_to_add;
  logic [1:0]      num_of_hearts;
  logic [1:0][3:0] level_num;
  logic            gameOver;
  logic [2:0]      state_out;

  modport master (
    output start_key, one_sec, out_of_time, player_hit, level_done,
    input  timer_load, time_to_add, num_of_hearts, level_num, gameOver, state_out
  );

  modport slave (
    input  start_key, one_sec, out_of_time, player_hit, level_done,
    output timer_load, time_to_add, num_of_hearts, level_num, gameOver, state_out
  );
endinterface

// File: rtl/game_sequencer.sv
// Game flow FSM (hearts, BCD level, hit pause); all outputs registered, one cycle after the input.
// No backpressure. Define LEVEL_BONUS_HEART_EN to award a heart (max 3) on every level-up.
module game_sequencer #(
  parameter int unsigned START_HEARTS = 3,
  parameter logic [7:0]  LEVEL_TIME   = 8'h60,
  parameter int unsigned PAUSE_SEC    = 2
) (
  input  logic            clk,
  input  logic            reset,
  game_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    PLAY      = 3'd2,
    HIT_PAUSE = 3'd3,
    LEVEL_UP  = 3'd4,
    GAME_OVER = 3'd5
  } state_e;

  localparam logic [1:0] START_H    = 2'(START_HEARTS);
  localparam logic [3:0] PAUSE_LAST = 4'(PAUSE_SEC - 1);

  state_e     state_q;
  logic [1:0] hearts_q;
  logic [7:0] level_q;
  logic [3:0] pause_cnt_q;
  logic       start_prev_q;
  logic       timer_load_q;
  logic       game_over_q;

  logic [1:0] hearts_dec_d;
  logic [7:0] level_inc_d;
  logic       start_rise_d;
  logic       hit_d;

  always_comb begin
    hearts_dec_d = (hearts_q == 2'd0) ? 2'd0 : hearts_q - 2'd1;
    start_rise_d = bus.start_key && !start_prev_q;
    // A simultaneous hit and timeout is one damage event.
    hit_d        = bus.player_hit || bus.out_of_time;
    if (level_q == 8'h99) begin
      level_inc_d = level_q;
    end else if (level_q[3:0] >= 4'd9) begin
      level_inc_d = {level_q[7:4] + 4'd1, 4'd0};
    end else begin
      level_inc_d = {level_q[7:4], level_q[3:0] + 4'd1};
    end
  end

  // Outputs are set on the transition into the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hearts_q     <= 2'd0;
      level_q      <= 8'h00;
      pause_cnt_q  <= 4'd0;
      start_prev_q <= 1'b1;
      timer_load_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      start_prev_q <= bus.start_key;
      timer_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_key) begin
            hearts_q     <= START_H;
            level_q      <= 8'h01;
            state_q      <= LOAD;
            timer_load_q <= 1'b1;
          end
        end
        LOAD: state_q <= PLAY;
        PLAY: begin
          if (bus.level_done) begin
            state_q <= LEVEL_UP;
          end else if (hit_d) begin
            hearts_q <= hearts_dec_d;
            if (hearts_dec_d == 2'd0) begin
              state_q     <= GAME_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q     <= HIT_PAUSE;
              pause_cnt_q <= 4'd0;
            end
          end
        end
        HIT_PAUSE: begin
          if (bus.one_sec) begin
            if (pause_cnt_q == PAUSE_LAST) begin
              pause_cnt_q  <= 4'd0;
              state_q      <= LOAD;
              timer_load_q <= 1'b1;
            end else begin
              pause_cnt_q <= pause_cnt_q + 4'd1;
            end
          end
        end
        LEVEL_UP: begin
          level_q      <= level_inc_d;
`ifdef LEVEL_BONUS_HEART_EN
          hearts_q     <= (hearts_q == 2'd3) ? 2'd3 : hearts_q + 2'd1;
`else
          hearts_q     <= hearts_q;
`endif
          state_q      <= LOAD;
          timer_load_q <= 1'b1;
        end
        GAME_OVER: begin
          if (start_rise_d) begin
            hearts_q     <= START_H;
            level_q      <= 8'h01;
            game_over_q  <= 1'b0;
            state_q      <= LOAD;
            timer_load_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.timer_load    = timer_load_q;
  assign bus.time_to_add   = LEVEL_TIME;
  assign bus.num_of_hearts = hearts_q;
  assign bus.level_num     = level_q;
  assign bus.gameOver      = game_over_q;
  assign bus.state_out     = state_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench: each step queues the expected next-cycle outputs, the tick pops and compares them.
module tb_game_sequencer;
  localparam int S_IDLE = 0, S_LOAD = 1, S_PLAY = 2, S_HP = 3, S_LVUP = 4, S_GO = 5;
`ifdef LEVEL_BONUS_HEART_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_sequencer_if gif();

  game_sequencer #(
    .START_HEARTS(3),
    .LEVEL_TIME  (8'h60),
    .PAUSE_SEC   (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (gif.slave)
  );

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [1:0] h;
    logic [7:0] lv;
    logic       tl;
    logic       go;
  } exp_t;

  exp_t       sb[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [1:0] cur_h;
  logic [7:0] cur_lv;

  function automatic logic [7:0] bcd_next(input logic [7:0] v);
    int d;
    d = int'(v[7:4]) * 10 + int'(v[3:0]);
    if (d < 99) d++;
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_next(input string tag, input int st, input logic [1:0] h,
                             input logic [7:0] lv, input logic tl, input logic go);
    exp_t e;
    e.tag = tag; e.st = 3'(st); e.h = h; e.lv = lv; e.tl = tl; e.go = go;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".state"},  8'(gif.state_out),     8'(e.st));
      chk({e.tag, ".hearts"}, 8'(gif.num_of_hearts), 8'(e.h));
      chk({e.tag, ".level"},  8'(gif.level_num),     e.lv);
      chk({e.tag, ".tload"},  8'(gif.timer_load),    8'(e.tl));
      chk({e.tag, ".gover"},  8'(gif.gameOver),      8'(e.go));
    end
  endtask

  task automatic pause_to_play(input string tag);
    gif.one_sec = 1'b1;
    expect_next({tag, ".p1"}, S_HP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    expect_next({tag, ".p2"}, S_LOAD, cur_h, cur_lv, 1'b1, 1'b0); tick();
    gif.one_sec = 1'b0;
    expect_next({tag, ".play"}, S_PLAY, cur_h, cur_lv, 1'b0, 1'b0); tick();
  endtask

  task automatic level_up();
    string t;
    t = $sformatf("lv%02h", cur_lv);
    gif.level_done = 1'b1;
    expect_next({t, ".up"}, S_LVUP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    gif.level_done = 1'b0;
    cur_lv = bcd_next(cur_lv);
    if (BONUS && cur_h < 2'd3) cur_h = cur_h + 2'd1;
    expect_next({t, ".load"}, S_LOAD, cur_h, cur_lv, 1'b1, 1'b0); tick();
    expect_next({t, ".play"}, S_PLAY, cur_h, cur_lv, 1'b0, 1'b0); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    gif.start_key = 1'b0; gif.one_sec = 1'b0; gif.out_of_time = 1'b0;
    gif.player_hit = 1'b0; gif.level_done = 1'b0;
    expect_next("reset", S_IDLE, 2'd0, 8'h00, 1'b0, 1'b0); tick();

    // Start and first load.
    reset = 1'b0; gif.start_key = 1'b1; cur_h = 2'd3; cur_lv = 8'h01;
    expect_next("start.load", S_LOAD, cur_h, cur_lv, 1'b1, 1'b0); tick();
    chk("time_to_add", 8'(gif.time_to_add), 8'h60);
    gif.start_key = 1'b0;
    expect_next("start.play", S_PLAY, cur_h, cur_lv, 1'b0, 1'b0); tick();
    expect_next("play.quiet", S_PLAY, cur_h, cur_lv, 1'b0, 1'b0); tick();

    // Hit, events ignored during pause, gaps between one_sec pulses.
    gif.player_hit = 1'b1; cur_h = 2'd2;
    expect_next("hit1", S_HP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    gif.out_of_time = 1'b1; gif.level_done = 1'b1;
    expect_next("hp.ignore", S_HP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    gif.player_hit = 1'b0; gif.out_of_time = 1'b0; gif.level_done = 1'b0;
    gif.one_sec = 1'b1;
    expect_next("hp.sec1", S_HP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    gif.one_sec = 1'b0;
    expect_next("hp.gap", S_HP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    gif.one_sec = 1'b1;
    expect_next("hp.sec2", S_LOAD, cur_h, cur_lv, 1'b1, 1'b0); tick();
    gif.one_sec = 1'b0;
    expect_next("hp.play", S_PLAY, cur_h, cur_lv, 1'b0, 1'b0); tick();

    // Held timeout costs one heart.
    gif.out_of_time = 1'b1; cur_h = 2'd1;
    expect_next("oot.1", S_HP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    expect_next("oot.2", S_HP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    gif.out_of_time = 1'b0;
    pause_to_play("oot");

    // Last heart lost to simultaneous hit and timeout; start already held.
    gif.player_hit = 1'b1; gif.out_of_time = 1'b1; gif.start_key = 1'b1; cur_h = 2'd0;
    expect_next("go.enter", S_GO, cur_h, cur_lv, 1'b0, 1'b1); tick();
    gif.player_hit = 1'b0; gif.level_done = 1'b1;
    expect_next("go.held1", S_GO, cur_h, cur_lv, 1'b0, 1'b1); tick();
    gif.level_done = 1'b0;
    expect_next("go.held2", S_GO, cur_h, cur_lv, 1'b0, 1'b1); tick();
    gif.start_key = 1'b0; gif.out_of_time = 1'b0;
    expect_next("go.release", S_GO, cur_h, cur_lv, 1'b0, 1'b1); tick();
    gif.start_key = 1'b1; cur_h = 2'd3; cur_lv = 8'h01;
    expect_next("go.restart", S_LOAD, cur_h, cur_lv, 1'b1, 1'b0); tick();
    gif.start_key = 1'b0;
    expect_next("go.play", S_PLAY, cur_h, cur_lv, 1'b0, 1'b0); tick();

    // Level-done beats a simultaneous hit.
    gif.player_hit = 1'b1; cur_h = 2'd2;
    expect_next("hit2", S_HP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    gif.player_hit = 1'b0;
    pause_to_play("hit2");
    gif.level_done = 1'b1; gif.player_hit = 1'b1;
    expect_next("both.up", S_LVUP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    gif.level_done = 1'b0; gif.player_hit = 1'b0;
    cur_lv = 8'h02; cur_h = BONUS ? 2'd3 : 2'd2;
    expect_next("both.load", S_LOAD, cur_h, cur_lv, 1'b1, 1'b0); tick();
    expect_next("both.play", S_PLAY, cur_h, cur_lv, 1'b0, 1'b0); tick();

    // Walk levels through every BCD carry up to saturation at 99.
    while (cur_lv != 8'h99) level_up();
    level_up();

    // Reset during a pause that would otherwise load this cycle.
    gif.player_hit = 1'b1; cur_h = cur_h - 2'd1;
    expect_next("rst.hp", S_HP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    gif.player_hit = 1'b0; gif.one_sec = 1'b1;
    expect_next("rst.sec1", S_HP, cur_h, cur_lv, 1'b0, 1'b0); tick();
    reset = 1'b1;
    expect_next("rst.pause", S_IDLE, 2'd0, 8'h00, 1'b0, 1'b0); tick();
    reset = 1'b0; gif.one_sec = 1'b0;
    expect_next("rst.idle", S_IDLE, 2'd0, 8'h00, 1'b0, 1'b0); tick();

    // Reset during LOAD.
    gif.start_key = 1'b1;
    expect_next("rstl.load", S_LOAD, 2'd3, 8'h01, 1'b1, 1'b0); tick();
    gif.start_key = 1'b0; reset = 1'b1;
    expect_next("rstl.idle", S_IDLE, 2'd0, 8'h00, 1'b0, 1'b0); tick();
    reset = 1'b0;
    expect_next("rstl.stay", S_IDLE, 2'd0, 8'h00, 1'b0, 1'b0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
